// File: rtl/fetch_hazard_if.sv
// Fetch/hazard controller bus: instruction memory return path, ID/EX hazard
// inputs, branch resolution inputs and the controller's fetch/pipeline outputs.
interface fetch_hazard_if #(
    parameter int XLEN  = 32,
    parameter int RA_W  = 5,
    parameter int CNT_W = 16
);
    logic [31:0]       imem_instr;
    logic              imem_valid;
    logic [XLEN-1:0]   pc;
    logic [31:0]       if_id_instr;
    logic [XLEN-1:0]   if_id_pc;
    logic              if_id_valid;
    logic [RA_W-1:0]   id_rs;
    logic [RA_W-1:0]   id_rt;
    logic              id_uses_rt;
    logic              id_jump;
    logic              ex_valid;
    logic              ex_memread;
    logic [RA_W-1:0]   ex_rd;
    logic              ex_branch_taken;
    logic [XLEN-1:0]   ex_branch_pc;
    logic [XLEN-1:0]   ex_branch_off;
    logic              id_ex_bubble;
    logic              id_ex_flush;
    logic [CNT_W-1:0]  cnt_stall;
    logic [CNT_W-1:0]  cnt_redirect;
    logic [CNT_W-1:0]  cnt_imem_wait;

    // Pipeline/memory side: drives instruction data and hazard inputs.
    modport master (
        output imem_instr, imem_valid, id_rs, id_rt, id_uses_rt, id_jump,
               ex_valid, ex_memread, ex_rd, ex_branch_taken, ex_branch_pc, ex_branch_off,
        input  pc, if_id_instr, if_id_pc, if_id_valid, id_ex_bubble, id_ex_flush,
               cnt_stall, cnt_redirect, cnt_imem_wait
    );

    // Controller side.
    modport slave (
        input  imem_instr, imem_valid, id_rs, id_rt, id_uses_rt, id_jump,
               ex_valid, ex_memread, ex_rd, ex_branch_taken, ex_branch_pc, ex_branch_off,
        output pc, if_id_instr, if_id_pc, if_id_valid, id_ex_bubble, id_ex_flush,
               cnt_stall, cnt_redirect, cnt_imem_wait
    );
endinterface

// File: rtl/fetch_hazard_ctrl.sv
// Fetch stage and hazard controller: owns PC and IF/ID, resolves redirects,
// load-use stalls and imem wait states with a fixed priority, and keeps
// saturating event counters.
module fetch_hazard_ctrl #(
    parameter int              XLEN     = 32,
    parameter int              RA_W     = 5,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 16
) (
    input logic           clk,
    input logic           reset,
    fetch_hazard_if.slave bus
);
    logic [XLEN-1:0]  pc_q;
    logic [31:0]      if_id_instr_q;
    logic [XLEN-1:0]  if_id_pc_q;
    logic             if_id_valid_q;
    logic [CNT_W-1:0] cnt_stall_q;
    logic [CNT_W-1:0] cnt_redirect_q;
    logic [CNT_W-1:0] cnt_imem_wait_q;

    logic             load_use;
    logic             take_branch;
    logic             take_jump;
    logic             take_stall;
    logic             take_wait;
    logic [XLEN-1:0]  branch_target;
    logic [XLEN-1:0]  if_pc_plus4;
    logic [XLEN-1:0]  jump_target;

    // Hazard detection and the one-hot priority decode of this cycle's action.
    always_comb begin
        load_use = if_id_valid_q && bus.ex_valid && bus.ex_memread &&
                   (bus.ex_rd != '0) &&
                   ((bus.ex_rd == bus.id_rs) || (bus.id_uses_rt && (bus.ex_rd == bus.id_rt)));
        take_branch = bus.ex_branch_taken;
        take_jump   = !take_branch && bus.id_jump && if_id_valid_q;
        take_stall  = !take_branch && !take_jump && load_use;
        take_wait   = !take_branch && !take_jump && !take_stall && !bus.imem_valid;
    end

    // Redirect targets; the jump keeps the upper PC bits of the slot after the jump.
    always_comb begin
        branch_target = bus.ex_branch_pc + XLEN'(4) + (bus.ex_branch_off << 2);
        if_pc_plus4   = if_id_pc_q + XLEN'(4);
        jump_target   = (if_pc_plus4 & {{(XLEN-28){1'b1}}, 28'b0}) |
                        XLEN'({if_id_instr_q[25:0], 2'b00});
    end

    // PC, IF/ID register and saturating counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q            <= RESET_PC;
            if_id_instr_q   <= '0;
            if_id_pc_q      <= '0;
            if_id_valid_q   <= 1'b0;
            cnt_stall_q     <= '0;
            cnt_redirect_q  <= '0;
            cnt_imem_wait_q <= '0;
        end else if (take_branch || take_jump) begin
            pc_q          <= take_branch ? branch_target : jump_target;
            if_id_valid_q <= 1'b0;
            if (cnt_redirect_q != '1) cnt_redirect_q <= cnt_redirect_q + CNT_W'(1);
        end else if (take_stall) begin
            if (cnt_stall_q != '1) cnt_stall_q <= cnt_stall_q + CNT_W'(1);
        end else if (take_wait) begin
            if_id_valid_q <= 1'b0;
            if (cnt_imem_wait_q != '1) cnt_imem_wait_q <= cnt_imem_wait_q + CNT_W'(1);
        end else begin
            if_id_instr_q <= bus.imem_instr;
            if_id_pc_q    <= pc_q;
            if_id_valid_q <= 1'b1;
            pc_q          <= pc_q + XLEN'(4);
        end
    end

    // Combinational ID/EX controls are suppressed while reset is held.
    always_comb begin
        bus.id_ex_bubble = !reset && take_stall;
        bus.id_ex_flush  = !reset && take_branch;
    end

    assign bus.pc            = pc_q;
    assign bus.if_id_instr   = if_id_instr_q;
    assign bus.if_id_pc      = if_id_pc_q;
    assign bus.if_id_valid   = if_id_valid_q;
    assign bus.cnt_stall     = cnt_stall_q;
    assign bus.cnt_redirect  = cnt_redirect_q;
    assign bus.cnt_imem_wait = cnt_imem_wait_q;
endmodule

// File: tb/tb_fetch_hazard_ctrl.sv
// Bench for fetch_hazard_ctrl: two instances (default counters at RESET_PC=0,
// and 2-bit counters starting near the top of the address space) driven by
// the same stimulus and compared every cycle against a behavioural model.
module tb_fetch_hazard_ctrl;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fetch_hazard_if #(.XLEN(32), .RA_W(5), .CNT_W(16)) bus0 ();
    fetch_hazard_if #(.XLEN(32), .RA_W(5), .CNT_W(2))  bus1 ();

    fetch_hazard_ctrl #(.XLEN(32), .RA_W(5), .RESET_PC(32'h0), .CNT_W(16)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0.slave));
    fetch_hazard_ctrl #(.XLEN(32), .RA_W(5), .RESET_PC(32'hFFFF_FFF0), .CNT_W(2)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1.slave));

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state per instance; counters are unbounded event counts.
    logic [31:0] m_pc [2];
    logic [31:0] m_instr [2];
    logic [31:0] m_ifpc [2];
    logic        m_valid [2];
    int          n_stall [2];
    int          n_redir [2];
    int          n_wait [2];
    logic [31:0] reset_pc [2];
    int          cnt_w [2];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] sat(input int n, input int w);
        int top;
        top = (1 << w) - 1;
        return (n > top) ? 64'(top) : 64'(n);
    endfunction

    // One clock cycle: drive inputs, check comb controls, clock, check state.
    task automatic step(input logic rst, input logic [31:0] instr, input logic iv,
                        input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                        input logic jmp, input logic exv, input logic exm,
                        input logic [4:0] exrd, input logic brt,
                        input logic [31:0] bpc, input logic [31:0] boff);
        logic        lu;
        logic        exp_bub;
        logic        exp_fl;
        logic [31:0] pc4;
        logic [63:0] g_bub [2];
        logic [63:0] g_fl [2];
        @(negedge clk);
        reset = rst;
        bus0.imem_instr = instr; bus1.imem_instr = instr;
        bus0.imem_valid = iv;    bus1.imem_valid = iv;
        bus0.id_rs = rs;         bus1.id_rs = rs;
        bus0.id_rt = rt;         bus1.id_rt = rt;
        bus0.id_uses_rt = urt;   bus1.id_uses_rt = urt;
        bus0.id_jump = jmp;      bus1.id_jump = jmp;
        bus0.ex_valid = exv;     bus1.ex_valid = exv;
        bus0.ex_memread = exm;   bus1.ex_memread = exm;
        bus0.ex_rd = exrd;       bus1.ex_rd = exrd;
        bus0.ex_branch_taken = brt; bus1.ex_branch_taken = brt;
        bus0.ex_branch_pc = bpc;    bus1.ex_branch_pc = bpc;
        bus0.ex_branch_off = boff;  bus1.ex_branch_off = boff;
        #1;
        g_bub[0] = 64'(bus0.id_ex_bubble); g_fl[0] = 64'(bus0.id_ex_flush);
        g_bub[1] = 64'(bus1.id_ex_bubble); g_fl[1] = 64'(bus1.id_ex_flush);
        for (int i = 0; i < 2; i++) begin
            lu = m_valid[i] && exv && exm && (exrd != 0) &&
                 ((exrd == rs) || (urt && (exrd == rt)));
            exp_bub = 1'b0;
            exp_fl  = 1'b0;
            if (rst) begin
                m_pc[i] = reset_pc[i]; m_instr[i] = '0; m_ifpc[i] = '0; m_valid[i] = 1'b0;
                n_stall[i] = 0; n_redir[i] = 0; n_wait[i] = 0;
            end else if (brt) begin
                exp_fl = 1'b1;
                m_pc[i] = bpc + 32'd4 + boff * 32'd4;
                m_valid[i] = 1'b0;
                n_redir[i]++;
            end else if (jmp && m_valid[i]) begin
                pc4 = m_ifpc[i] + 32'd4;
                m_pc[i] = {pc4[31:28], m_instr[i][25:0], 2'b00};
                m_valid[i] = 1'b0;
                n_redir[i]++;
            end else if (lu) begin
                exp_bub = 1'b1;
                n_stall[i]++;
            end else if (!iv) begin
                m_valid[i] = 1'b0;
                n_wait[i]++;
            end else begin
                m_instr[i] = instr; m_ifpc[i] = m_pc[i]; m_valid[i] = 1'b1;
                m_pc[i] = m_pc[i] + 32'd4;
            end
            check_eq($sformatf("bubble%0d", i), g_bub[i], 64'(exp_bub));
            check_eq($sformatf("flush%0d", i), g_fl[i], 64'(exp_fl));
        end
        @(posedge clk);
        #1;
        check_eq("pc0", 64'(bus0.pc), 64'(m_pc[0]));
        check_eq("pc1", 64'(bus1.pc), 64'(m_pc[1]));
        check_eq("valid0", 64'(bus0.if_id_valid), 64'(m_valid[0]));
        check_eq("valid1", 64'(bus1.if_id_valid), 64'(m_valid[1]));
        check_eq("instr0", 64'(bus0.if_id_instr), 64'(m_instr[0]));
        check_eq("instr1", 64'(bus1.if_id_instr), 64'(m_instr[1]));
        check_eq("ifpc0", 64'(bus0.if_id_pc), 64'(m_ifpc[0]));
        check_eq("ifpc1", 64'(bus1.if_id_pc), 64'(m_ifpc[1]));
        check_eq("stall0", 64'(bus0.cnt_stall), sat(n_stall[0], cnt_w[0]));
        check_eq("stall1", 64'(bus1.cnt_stall), sat(n_stall[1], cnt_w[1]));
        check_eq("redir0", 64'(bus0.cnt_redirect), sat(n_redir[0], cnt_w[0]));
        check_eq("redir1", 64'(bus1.cnt_redirect), sat(n_redir[1], cnt_w[1]));
        check_eq("wait0", 64'(bus0.cnt_imem_wait), sat(n_wait[0], cnt_w[0]));
        check_eq("wait1", 64'(bus1.cnt_imem_wait), sat(n_wait[1], cnt_w[1]));
    endtask

    // Plain fetch cycle with no hazards in flight.
    task automatic fetch(input logic [31:0] instr);
        step(1'b0, instr, 1'b1, 5'd1, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0);
    endtask

    // LW $2 in EX while ID reads rs=$2.
    task automatic load_use_cycle();
        step(1'b0, 32'h1111_1111, 1'b1, 5'd2, 5'd7, 1'b0, 1'b0, 1'b1, 1'b1, 5'd2, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        logic [15:0] off16;
        reset_pc[0] = 32'h0;         cnt_w[0] = 16;
        reset_pc[1] = 32'hFFFF_FFF0; cnt_w[1] = 2;
        for (int i = 0; i < 2; i++) begin
            m_pc[i] = '0; m_instr[i] = '0; m_ifpc[i] = '0; m_valid[i] = 1'b0;
            n_stall[i] = 0; n_redir[i] = 0; n_wait[i] = 0;
        end
        reset = 1'b1;

        step(1'b1, 32'h0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0);
        step(1'b1, 32'h0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b1, 32'h0, 32'h0);
        check_eq("rst_pc0", 64'(bus0.pc), 64'h0);
        check_eq("rst_pc1", 64'(bus1.pc), 64'hFFFF_FFF0);

        // Straight-line fetch: 0,4,8,12 and wrap of the high-PC instance.
        fetch(32'h2000_0001);
        fetch(32'h2000_0002);
        fetch(32'h2000_0003);
        check_eq("seq_pc0", 64'(bus0.pc), 64'd12);
        check_eq("seq_valid0", 64'(bus0.if_id_valid), 64'd1);
        fetch(32'h2000_0004);
        check_eq("wrap_pc1", 64'(bus1.pc), 64'h0);

        // Load-use stall, then the same load targeting $0 causes no stall.
        load_use_cycle();
        check_eq("lu_stall0", 64'(bus0.cnt_stall), 64'd1);
        step(1'b0, 32'h3333_3333, 1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 32'h0, 32'h0);

        // Taken branch at 0x10 with offset 3.
        step(1'b0, 32'h0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 32'h10, 32'd3);
        check_eq("br_pc0", 64'(bus0.pc), 64'h20);
        check_eq("br_redir0", 64'(bus0.cnt_redirect), 64'd1);

        // Branch coincident with load-use and jump: branch wins, no bubble.
        fetch(32'h0800_0040);
        step(1'b0, 32'h0, 1'b1, 5'd2, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd2, 1'b1, 32'h100, 32'hFFFF_FFFF);
        check_eq("brwin_pc0", 64'(bus0.pc), 64'h100);

        // Three imem wait states, then fetch resumes at the same pc.
        for (int k = 0; k < 3; k++)
            step(1'b0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0);
        check_eq("wait_cnt0", 64'(bus0.cnt_imem_wait), 64'd3);
        check_eq("wait_pc0", 64'(bus0.pc), 64'h100);
        fetch(32'h0C00_0010);
        check_eq("resume_ifpc0", 64'(bus0.if_id_pc), 64'h100);

        // Jump in ID redirects to the jump target.
        step(1'b0, 32'h0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0);
        check_eq("jmp_pc0", 64'(bus0.pc), 64'h40);
        fetch(32'h0);

        // Five load-use hazards saturate the 2-bit counter.
        for (int k = 0; k < 5; k++) begin
            load_use_cycle();
            fetch(32'h4000_0000 + 32'(k));
        end
        check_eq("sat_stall1", 64'(bus1.cnt_stall), 64'd3);
        check_eq("sat_stall0", 64'(bus0.cnt_stall), 64'd6);

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            off16 = 16'($urandom);
            step(($urandom_range(0, 99) == 0),
                 $urandom,
                 ($urandom_range(0, 99) < 85),
                 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 9) < 8),
                 ($urandom_range(0, 9) < 4),
                 5'($urandom_range(0, 3)),
                 ($urandom_range(0, 99) < 8),
                 $urandom & 32'hFFFF_FFFC,
                 {{16{off16[15]}}, off16});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
